mem_ctrl: RTL and testbench

Memory access sequencer between the simple CPU core and the 4-word `ram` block. It accepts a single-word read or write request from the core and generates the RAM's address, data-in, `read`/`write` strobes and active-low enable in a fixed, glitch-free sequence. It captures read data into a holding register and signals completion with a one-cycle `ack`.

---
 rtl/mem_ctrl.sv | 100 ++++++++++
 tb/tb_mem_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-word RAM access sequencer (IDLE/SETUP/STROBE/DONE); define MEM_CTRL_RANGE_CHK_EN to short-circuit out-of-range requests
module mem_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int NUM_WORDS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [5:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic [7:0] rdata_o,
  output logic       ack_o,
  output logic       err_o,
  output logic       busy_o,
  output logic [5:0] ram_addr_o,
  output logic [7:0] ram_din_o,
  input  logic [7:0] ram_data_i,
  output logic       ram_read_o,
  output logic       ram_write_o,
  output logic       ram_ena_n_o
);
`ifdef MEM_CTRL_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  localparam logic [6:0] NW = 7'(NUM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [7:0]  rdata_q;
  logic        ack_q, err_q, busy_q, read_q, write_q, ena_n_q;
  logic [5:0]  addr_q;
  logic [7:0]  din_q;
  logic        oor;
  assign oor = RANGE_CHK && ({1'b0, req_addr_i} >= NW);
  // Sequencer: every RAM-facing and core-facing output is a flop so the strobes never glitch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ena_n_q <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (req_i) begin
          addr_q  <= req_addr_i;
          din_q   <= req_wdata_i;
          we_q    <= we_i;
          busy_q  <= 1'b1;
          ack_q   <= oor;
          err_q   <= oor;
          state_q <= oor ? DONE : SETUP;
        end
        SETUP: begin
          ena_n_q <= 1'b0;
          read_q  <= ~we_q;
          write_q <= we_q;
          cnt_q   <= CNT_INIT;
          state_q <= STROBE;
        end
        STROBE: if (cnt_q == 4'd0) begin
          ena_n_q <= 1'b1;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          ack_q   <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= we_q ? rdata_q : ram_data_i;
          state_q <= DONE;
        end else cnt_q <= cnt_q - 4'd1;
        DONE: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign ram_addr_o  = addr_q;
  assign ram_din_o   = din_q;
  assign ram_read_o  = read_q;
  assign ram_write_o = write_q;
  assign ram_ena_n_o = ena_n_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl with WAIT_CYCLES=1 (a_*) and WAIT_CYCLES=3 (b_*) against a 4-word RAM model
module tb_mem_ctrl;
  logic clk, rst, a_req, b_req, we;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] a_rdata, b_rdata, a_din, b_din, a_data, b_data;
  logic [5:0] a_addr, b_addr;
  logic a_ack, a_err, a_busy, a_read, a_write, a_ena_n;
  logic b_ack, b_err, b_busy, b_read, b_write, b_ena_n;
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  int vec = 0, miss = 0;

  mem_ctrl #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(we), .req_addr_i(addr), .req_wdata_i(wdata),
    .rdata_o(a_rdata), .ack_o(a_ack), .err_o(a_err), .busy_o(a_busy), .ram_addr_o(a_addr),
    .ram_din_o(a_din), .ram_data_i(a_data), .ram_read_o(a_read), .ram_write_o(a_write),
    .ram_ena_n_o(a_ena_n));

  mem_ctrl #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(we), .req_addr_i(addr), .req_wdata_i(wdata),
    .rdata_o(b_rdata), .ack_o(b_ack), .err_o(b_err), .busy_o(b_busy), .ram_addr_o(b_addr),
    .ram_din_o(b_din), .ram_data_i(b_data), .ram_read_o(b_read), .ram_write_o(b_write),
    .ram_ena_n_o(b_ena_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_data = (!a_ena_n && a_read && a_addr < 6'd4) ? mem_a[a_addr[1:0]] : 8'hzz;
  assign b_data = (!b_ena_n && b_read && b_addr < 6'd4) ? mem_b[b_addr[1:0]] : 8'hzz;
  always @(posedge clk) if (!a_ena_n && a_write && a_addr < 6'd4) mem_a[a_addr[1:0]] <= a_din;
  always @(posedge clk) if (!b_ena_n && b_write && b_addr < 6'd4) mem_b[b_addr[1:0]] <= b_din;

  task automatic tick;
    @(negedge clk);
  endtask

  // Raises req for exactly one sampling edge; returns at the negedge after E0
  task automatic issue(input bit sel, input logic w, input logic [5:0] ad, input logic [7:0] d);
    we = w; addr = ad; wdata = d;
    if (sel) b_req = 1'b1; else a_req = 1'b1;
    tick;
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    vec++; if (a_rdata !== 8'h00) begin miss++; $display("FAIL reset_rdata: got %h want 00", a_rdata); end
    vec++; if ({a_ack, a_err, a_busy} !== 3'b000) begin miss++; $display("FAIL reset_ack_err_busy: got %b want 000", {a_ack, a_err, a_busy}); end
    vec++; if ({a_addr, a_din} !== 14'd0) begin miss++; $display("FAIL reset_addr_din: got %h/%h want 00/00", a_addr, a_din); end
    vec++; if ({a_read, a_write, a_ena_n} !== 3'b001) begin miss++; $display("FAIL reset_strobes: got %b want 001", {a_read, a_write, a_ena_n}); end
    vec++; if ({b_busy, b_ena_n, b_rdata} !== {1'b0, 1'b1, 8'h00}) begin miss++; $display("FAIL reset_b: got %b/%b/%h want 0/1/00", b_busy, b_ena_n, b_rdata); end
  endtask

  task automatic test_read;
    issue(1'b0, 1'b0, 6'd2, 8'h00);
    vec++; if ({a_busy, a_ena_n, a_read} !== 3'b110) begin miss++; $display("FAIL read_setup: busy/ena_n/read got %b want 110", {a_busy, a_ena_n, a_read}); end
    vec++; if (a_addr !== 6'd2) begin miss++; $display("FAIL read_addr: got %0d want 2", a_addr); end
    tick;
    vec++; if ({a_ena_n, a_read, a_write, a_ack} !== 4'b0100) begin miss++; $display("FAIL read_strobe: ena_n/read/write/ack got %b want 0100", {a_ena_n, a_read, a_write, a_ack}); end
    tick;
    vec++; if ({a_ack, a_err, a_ena_n, a_read} !== 4'b1010) begin miss++; $display("FAIL read_done: ack/err/ena_n/read got %b want 1010", {a_ack, a_err, a_ena_n, a_read}); end
    vec++; if (a_rdata !== 8'h02) begin miss++; $display("FAIL read_rdata: got %h want 02", a_rdata); end
    tick;
    vec++; if ({a_ack, a_busy} !== 2'b00) begin miss++; $display("FAIL read_idle: ack/busy got %b want 00", {a_ack, a_busy}); end
  endtask

  task automatic test_write_read;
    issue(1'b0, 1'b1, 6'd1, 8'hA5);
    vec++; if (a_din !== 8'hA5) begin miss++; $display("FAIL write_din: got %h want a5", a_din); end
    tick;
    vec++; if ({a_ena_n, a_read, a_write} !== 3'b001) begin miss++; $display("FAIL write_strobe: ena_n/read/write got %b want 001", {a_ena_n, a_read, a_write}); end
    tick;
    vec++; if ({a_ack, a_write, a_ena_n} !== 3'b101) begin miss++; $display("FAIL write_done: ack/write/ena_n got %b want 101", {a_ack, a_write, a_ena_n}); end
    vec++; if (a_rdata !== 8'h02) begin miss++; $display("FAIL write_keeps_rdata: got %h want 02", a_rdata); end
    tick;
    issue(1'b0, 1'b0, 6'd1, 8'h00);
    repeat (2) tick;
    vec++; if ({a_ack, a_rdata} !== {1'b1, 8'hA5}) begin miss++; $display("FAIL write_readback: ack/rdata got %b/%h want 1/a5", a_ack, a_rdata); end
    tick;
  endtask

  task automatic test_busy;
    int n_ack = 0;
    issue(1'b0, 1'b0, 6'd3, 8'h00);
    for (int i = 0; i < 8; i++) begin
      a_req = (i < 3); addr = 6'd0; we = 1'b0;
      tick;
      if (a_ack) n_ack++;
    end
    a_req = 1'b0;
    vec++; if (n_ack !== 1) begin miss++; $display("FAIL busy_ack_count: got %0d want 1", n_ack); end
    vec++; if (a_addr !== 6'd3) begin miss++; $display("FAIL busy_addr: got %0d want 3", a_addr); end
    vec++; if ({a_rdata, a_busy} !== {8'h03, 1'b0}) begin miss++; $display("FAIL busy_rdata: rdata/busy got %h/%b want 03/0", a_rdata, a_busy); end
  endtask

  task automatic test_range;
    bit saw_low = 1'b0;
    issue(1'b0, 1'b0, 6'd5, 8'h00);
`ifdef MEM_CTRL_RANGE_CHK_EN
    vec++; if ({a_ack, a_err, a_ena_n} !== 3'b111) begin miss++; $display("FAIL range_done: ack/err/ena_n got %b want 111", {a_ack, a_err, a_ena_n}); end
    vec++; if (a_rdata !== 8'h03) begin miss++; $display("FAIL range_rdata: got %h want 03", a_rdata); end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (!a_ena_n || a_read) saw_low = 1'b1;
    end
    vec++; if ({saw_low, a_ack, a_busy} !== 3'b000) begin miss++; $display("FAIL range_quiet: strobe/ack/busy got %b want 000", {saw_low, a_ack, a_busy}); end
`else
    vec++; if ({a_ack, a_busy} !== 2'b01) begin miss++; $display("FAIL range_setup: ack/busy got %b want 01", {a_ack, a_busy}); end
    tick;
    saw_low = !a_ena_n && a_read;
    tick;
    vec++; if ({saw_low, a_ack, a_err} !== 3'b110) begin miss++; $display("FAIL range_full_seq: strobe/ack/err got %b want 110", {saw_low, a_ack, a_err}); end
    tick;
`endif
  endtask

  task automatic test_reset_strobe;
    bit saw_ack = 1'b0;
    issue(1'b1, 1'b0, 6'd2, 8'h00);
    tick;
    vec++; if ({b_ena_n, b_read} !== 2'b01) begin miss++; $display("FAIL rs_strobe: ena_n/read got %b want 01", {b_ena_n, b_read}); end
    tick;
    #2 rst = 1'b1;
    #1;
    vec++; if ({b_ena_n, b_read, b_ack, b_busy} !== 4'b1000) begin miss++; $display("FAIL rs_async: ena_n/read/ack/busy got %b want 1000", {b_ena_n, b_read, b_ack, b_busy}); end
    vec++; if (a_rdata !== 8'h00) begin miss++; $display("FAIL rs_rdata_clear: got %h want 00", a_rdata); end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (b_ack) saw_ack = 1'b1;
    end
    vec++; if (saw_ack !== 1'b0) begin miss++; $display("FAIL rs_no_ack: got %b want 0", saw_ack); end
    issue(1'b1, 1'b0, 6'd3, 8'h00);
    repeat (3) tick;
    vec++; if ({b_ack, b_ena_n} !== 2'b00) begin miss++; $display("FAIL rs_latency: ack/ena_n at E3 got %b want 00", {b_ack, b_ena_n}); end
    tick;
    vec++; if ({b_ack, b_rdata} !== {1'b1, 8'h03}) begin miss++; $display("FAIL rs_readback: ack/rdata got %b/%h want 1/03", b_ack, b_rdata); end
    tick;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(i);
    end
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick;
    test_reset;
    test_read;
    test_write_read;
    test_busy;
    test_range;
    test_reset_strobe;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
